// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit FIFO.
// State encodings match the frame phases on the wire.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // 24 MHz board clock at 115200 baud
  localparam int BAUD_DIV_24M = 208;
  localparam int FIFO_AW_DEF  = 9;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO.
// Drops writes when full unless a pop frees a slot that cycle.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_res_n,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign pop   = ren && !empty;
  assign push  = wen && (!full || pop);
  assign full  = count[AW];
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wen && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by an unthrottled byte producer.
// Back-to-back frames leave the STOP bit straight into the next START.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_24M,
  parameter int FIFO_AW  = FIFO_AW_DEF
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_wen,
  input  logic [7:0] i_wdata,
  output logic       o_uart_tx,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_e     state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic          baud_end;
  logic          pop;
  logic [7:0]    head;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign pop = !o_empty &&
               (state == IDLE || (state == STOP && baud_end));
  assign o_busy = (state != IDLE);

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_res_n  (i_res_n),
    .wen      (i_wen),
    .wdata    (i_wdata),
    .ren      (pop),
    .rdata    (head),
    .full     (o_full),
    .empty    (o_empty),
    .overflow (o_overflow)
  );

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state     <= IDLE;
      o_uart_tx <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!o_empty) begin
            shreg     <= head;
            o_uart_tx <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            o_uart_tx <= shreg[0];
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              o_uart_tx <= 1'b1;
              state     <= STOP;
            end else begin
              shreg     <= shreg >> 1;
              o_uart_tx <= shreg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // chain straight into the next start bit
            if (!o_empty) begin
              shreg     <= head;
              o_uart_tx <= 1'b0;
              bit_cnt   <= '0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at BAUD_DIV=4, depth 4.
// A line monitor decodes frames and records their start cycles.
module tb_uart_tx_fifo;

  localparam int BD    = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * BD;

  logic       i_clk   = 1'b0;
  logic       i_res_n = 1'b0;
  logic       i_wen   = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  logic       o_uart_tx;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wlast  = 0;
  bit rst_seen = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  uart_tx_fifo #(
    .BAUD_DIV (BD),
    .FIFO_AW  (AW)
  ) dut (
    .i_clk      (i_clk),
    .i_res_n    (i_res_n),
    .i_wen      (i_wen),
    .i_wdata    (i_wdata),
    .o_uart_tx  (o_uart_tx),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_res_n) rst_seen = 1'b1;

  initial begin : mon
    logic [7:0] d;
    int t;
    bit ok;
    forever begin
      @(negedge i_clk);
      if (i_res_n === 1'b1 && o_uart_tx === 1'b0) begin
        t = cyc;
        ok = 1'b1;
        rst_seen = 1'b0;
        repeat (2) @(negedge i_clk);
        if (o_uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge i_clk);
          d[i] = o_uart_tx;
        end
        repeat (BD) @(negedge i_clk);
        if (o_uart_tx !== 1'b1) ok = 1'b0;
        @(negedge i_clk);
        if (!rst_seen) begin
          rx_q.push_back(d);
          rx_t.push_back(ok ? t : -1);
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    i_wen   = 1'b1;
    i_wdata = d;
    if (accept) exp_q.push_back(d);
    @(posedge i_clk);
    #1;
    i_wen = 1'b0;
    wlast = cyc;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge i_clk);
      k++;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_res_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_res_n = 1'b1;
    @(negedge i_clk);
    clear_sb();
  endtask

  task automatic test_reset();
    i_res_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx got=%b exp=1", o_uart_tx);
    end
    checks++;
    if ({o_full, o_empty, o_overflow, o_busy} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0100",
               {o_full, o_empty, o_overflow, o_busy});
    end
    i_res_n = 1'b1;
    @(negedge i_clk);
    clear_sb();
  endtask

  task automatic test_single();
    int t0;
    logic [7:0] b;
    int t;
    wr(8'h53, 1'b1);
    t0 = wlast;
    checks++;
    if (o_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_empty_fall got=%b exp=0", o_empty);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_uart_tx !== 1'b0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop tx=%b empty=%b exp tx=0 empty=1",
               o_uart_tx, o_empty);
    end
    while (cyc < t0 + 1 + FRAME - 1) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_end got=%b exp=1", o_busy);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop got=%b exp=0", o_busy);
    end
    wait_rx(1, 20);
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL single_count got=%0d exp=1", rx_q.size());
    end else begin
      b = rx_q.pop_front();
      t = rx_t.pop_front();
      checks++;
      if (b !== exp_q.pop_front()) begin
        errors++;
        $display("FAIL single_byte got=%h exp=53", b);
      end
      checks++;
      if (t != t0 + 1) begin
        errors++;
        $display("FAIL single_start got=%0d exp=%0d", t, t0 + 1);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] msg [5];
    int t0;
    logic [7:0] b;
    logic [7:0] e;
    int t;
    msg = '{8'h34, 8'h31, 8'h20, 8'h41, 8'h20};
    clear_sb();
    for (int i = 0; i < 5; i++) begin
      wr(msg[i], 1'b1);
      if (i == 0) t0 = wlast;
    end
    while (cyc < t0 + 5 * FRAME) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy_end got=%b exp=1", o_busy);
    end
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL burst_done busy=%b empty=%b exp 0 1",
               o_busy, o_empty);
    end
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_ovf got=%b exp=0", o_overflow);
    end
    wait_rx(5, 20);
    checks++;
    if (rx_q.size() != 5) begin
      errors++;
      $display("FAIL burst_count got=%0d exp=5", rx_q.size());
    end
    for (int i = 0; i < 5 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      t = rx_t.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL burst_byte%0d got=%h exp=%h", i, b, e);
      end
      checks++;
      if (t != t0 + 1 + i * FRAME) begin
        errors++;
        $display("FAIL burst_start%0d got=%0d exp=%0d",
                 i, t, t0 + 1 + i * FRAME);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic [7:0] e;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      wr(8'(i), i <= 5);
      if (i == 5) begin
        checks++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_w5 full=%b ovf=%b exp 1 0",
                   o_full, o_overflow);
        end
      end
      if (i == 6) begin
        checks++;
        if (o_overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_w6 got=%b exp=1", o_overflow);
        end
      end
    end
    wait_rx(5, 5 * FRAME + 40);
    checks++;
    if (rx_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_count got=%0d exp=5", rx_q.size());
    end
    for (int i = 0; i < 5 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      void'(rx_t.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL ovf_byte%0d got=%h exp=%h", i, b, e);
      end
    end
    repeat (FRAME) @(negedge i_clk);
    checks++;
    if (rx_q.size() != 0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky extra=%0d ovf=%b exp 0 1",
               rx_q.size(), o_overflow);
    end
  endtask

  task automatic test_full_pop();
    int t0;
    logic [7:0] b;
    logic [7:0] e;
    int t;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(8'hC0 + 8'(i), 1'b1);
      if (i == 0) t0 = wlast;
    end
    checks++;
    if (o_full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_full got=%b exp=1", o_full);
    end
    while (cyc < t0 + FRAME) begin
      @(posedge i_clk);
      #1;
    end
    wr(8'hC5, 1'b1);
    checks++;
    if (o_overflow !== 1'b0 || o_full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_accept ovf=%b full=%b exp 0 1",
               o_overflow, o_full);
    end
    wait_rx(6, 6 * FRAME + 40);
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL fullpop_count got=%0d exp=6", rx_q.size());
    end
    for (int i = 0; i < 6 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      t = rx_t.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (b !== e || t != t0 + 1 + i * FRAME) begin
        errors++;
        $display("FAIL fullpop_frame%0d got=%h@%0d exp=%h@%0d",
                 i, b, t, e, t0 + 1 + i * FRAME);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int k;
    logic [7:0] b;
    logic [7:0] e;
    do_reset();
    while (n < 10) begin
      for (int j = 0; j < 3 && n < 10; j++) begin
        wr(8'hA0 + 8'(n), 1'b1);
        n++;
      end
      k = 0;
      @(negedge i_clk);
      while (!(o_empty && !o_busy) && k < 4 * FRAME) begin
        @(negedge i_clk);
        k++;
      end
      checks++;
      if (k >= 4 * FRAME) begin
        errors++;
        $display("FAIL wrap_drain_timeout got=%0d exp<%0d",
                 k, 4 * FRAME);
      end
    end
    wait_rx(10, 20);
    checks++;
    if (rx_q.size() != 10 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count got=%0d empty=%b exp 10 1",
               rx_q.size(), o_empty);
    end
    for (int i = 0; i < 10 && rx_q.size() > 0; i++) begin
      b = rx_q.pop_front();
      void'(rx_t.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++;
        $display("FAIL wrap_byte%0d got=%h exp=%h", i, b, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(8'h00, 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    repeat (15) @(posedge i_clk);
    #3;
    checks++;
    if (o_uart_tx !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre tx=%b busy=%b exp 0 1",
               o_uart_tx, o_busy);
    end
    i_res_n = 1'b0;
    #1;
    checks++;
    if (o_uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_tx got=%b exp=1", o_uart_tx);
    end
    checks++;
    if (o_empty !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags empty=%b busy=%b exp 1 0",
               o_empty, o_busy);
    end
    repeat (2) @(negedge i_clk);
    i_res_n = 1'b1;
    repeat (3 * FRAME) @(negedge i_clk);
    checks++;
    if (rx_q.size() != 0 || o_uart_tx !== 1'b1 || o_empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_quiet frames=%0d tx=%b empty=%b exp 0 1 1",
               rx_q.size(), o_uart_tx, o_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
